key_conditioner: RTL and testbench

Conditions the raw DE2 pushbutton inputs before they reach the Qsys keys PIO (`keys_external_connection_export`). Each key gets:
- a two-flop synchroniser,
- a per-key debounce state machine,
- one-cycle press and release pulses.

Nios software and the traffic-light FSM therefore see clean, glitch-free levels, and fabric logic gets edge events without polling. The block sits between the board key pins and the QSYS instance in the top level.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debounce_bit.sv | 100 ++++++++++
 rtl/key_conditioner.sv | 49 ++++
 tb/tb_key_conditioner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared debounce state encoding and default timing constant.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t RELEASED   = 2'd0;
    localparam key_state_t PRESS_PEND = 2'd1;
    localparam key_state_t PRESSED    = 2'd2;
    localparam key_state_t REL_PEND   = 2'd3;

    // 10 ms at 50 MHz
    localparam int KEY_STABLE_CYCLES_50MHZ = 500000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_bit
// Description : Synchroniser, stability counter, FSM and edge pulses for one key.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bit
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                 c_cnt_w        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    // The edge that moves the counter onto STABLE_CYCLES-1 is the accepting edge.
    localparam logic [c_cnt_w-1:0] c_cnt_last     = c_cnt_w'(STABLE_CYCLES - 2);
    localparam logic               c_released_pin = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic               r_sync1;
    logic               r_sync2;
    key_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;
    logic               r_release;

    logic               w_pressed;
    key_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_press_nxt;
    logic               w_release_nxt;

    assign w_pressed = r_sync2 ^ c_released_pin;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_pressed) w_state_nxt = PRESS_PEND;
            end
            PRESS_PEND: begin
                if (!w_pressed) begin
                    w_state_nxt = RELEASED;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = PRESSED;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            PRESSED: begin
                if (!w_pressed) w_state_nxt = REL_PEND;
            end
            REL_PEND: begin
                if (w_pressed) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt   = RELEASED;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: w_state_nxt = RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= c_released_pin;
            r_sync2   <= c_released_pin;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_raw;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = (r_state == PRESSED) || (r_state == REL_PEND);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Debounces the board pushbuttons and drives the keys PIO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner
    import key_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = KEY_STABLE_CYCLES_50MHZ,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] keys_export
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_key
            key_debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .ACTIVE_LOW    (ACTIVE_LOW)
            ) u_bit (
                .clk       (clk_clk),
                .rst       (reset_reset),
                .i_key_raw (key_raw[i]),
                .o_level   (key_level[i]),
                .o_press   (key_press[i]),
                .o_release (key_release[i])
            );
        end
    endgenerate

    // The PIO expects the raw pin polarity.
    generate
        if (ACTIVE_LOW != 0) begin : g_export_inv
            assign keys_export = ~key_level;
        end else begin : g_export_dir
            assign keys_export = key_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_conditioner
// Description : Directed self-checking bench for key_conditioner (STABLE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_conditioner;

    logic       clk_clk;
    logic       reset_reset;
    logic [2:0] key_raw;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic [2:0] keys_export;

    int tests_run    = 0;
    int tests_failed = 0;

    key_conditioner #(
        .WIDTH         (3),
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .keys_export (keys_export)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Advance one active edge and settle; inputs set after this land on the next edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        key_raw     = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (key_level !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_level got=%b exp=%b", key_level, 3'b000);
        end
        tests_run++;
        if (key_press !== 3'b000 || key_release !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses got press=%b release=%b exp=000/000", key_press, key_release);
        end
        tests_run++;
        if (keys_export !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_export got=%b exp=%b", keys_export, 3'b111);
        end
        reset_reset = 1'b0;
        tick();
        tests_run++;
        if (key_level !== 3'b000 || keys_export !== 3'b111) begin
            tests_failed++;
            $display("FAIL post_reset_idle got level=%b export=%b exp=000/111", key_level, keys_export);
        end
    endtask

    task automatic test_clean_press();
        key_raw = 3'b110;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (key_press !== ((e == 6) ? 3'b001 : 3'b000)) begin
                tests_failed++;
                $display("FAIL press_pulse edge=%0d got=%b exp=%b", e, key_press, (e == 6) ? 3'b001 : 3'b000);
            end
            tests_run++;
            if (key_level !== ((e >= 6) ? 3'b001 : 3'b000) || key_release !== 3'b000) begin
                tests_failed++;
                $display("FAIL press_level edge=%0d got level=%b release=%b exp level=%b release=000",
                         e, key_level, key_release, (e >= 6) ? 3'b001 : 3'b000);
            end
        end
        tests_run++;
        if (keys_export !== 3'b110) begin
            tests_failed++;
            $display("FAIL press_export got=%b exp=%b", keys_export, 3'b110);
        end
    endtask

    task automatic test_bounce();
        logic [13:0] seq;
        seq = 14'b11111111000100; // bit i drives cycle i: low 2, high 1, low 3, then high
        for (int i = 0; i < 14; i++) begin
            key_raw[1] = seq[i];
            tick();
            tests_run++;
            if (key_level !== 3'b001 || key_press !== 3'b000 || key_release !== 3'b000) begin
                tests_failed++;
                $display("FAIL bounce cycle=%0d got level=%b press=%b release=%b exp 001/000/000",
                         i, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_release();
        key_raw = 3'b111;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (key_release !== ((e == 6) ? 3'b001 : 3'b000) || key_press !== 3'b000) begin
                tests_failed++;
                $display("FAIL release_pulse edge=%0d got release=%b press=%b exp release=%b press=000",
                         e, key_release, key_press, (e == 6) ? 3'b001 : 3'b000);
            end
            tests_run++;
            if (key_level !== ((e < 6) ? 3'b001 : 3'b000)) begin
                tests_failed++;
                $display("FAIL release_level edge=%0d got=%b exp=%b", e, key_level, (e < 6) ? 3'b001 : 3'b000);
            end
        end
        tests_run++;
        if (keys_export !== 3'b111) begin
            tests_failed++;
            $display("FAIL release_export got=%b exp=%b", keys_export, 3'b111);
        end
    endtask

    task automatic test_simultaneous();
        key_raw = 3'b001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (key_press !== ((e == 6) ? 3'b110 : 3'b000)) begin
                tests_failed++;
                $display("FAIL simul_press edge=%0d got=%b exp=%b", e, key_press, (e == 6) ? 3'b110 : 3'b000);
            end
            tests_run++;
            if (key_level !== ((e >= 6) ? 3'b110 : 3'b000)) begin
                tests_failed++;
                $display("FAIL simul_level edge=%0d got=%b exp=%b", e, key_level, (e >= 6) ? 3'b110 : 3'b000);
            end
        end
        tests_run++;
        if (keys_export !== 3'b001) begin
            tests_failed++;
            $display("FAIL simul_export got=%b exp=%b", keys_export, 3'b001);
        end
    endtask

    task automatic test_reset_mid_press();
        key_raw     = 3'b011;
        reset_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (key_level !== 3'b000 || key_release !== 3'b000 || key_press !== 3'b000) begin
                tests_failed++;
                $display("FAIL midreset_hold cycle=%0d got level=%b release=%b press=%b exp 000/000/000",
                         i, key_level, key_release, key_press);
            end
        end
        reset_reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            tests_run++;
            if (key_press !== ((e == 6) ? 3'b100 : 3'b000) || key_release !== 3'b000) begin
                tests_failed++;
                $display("FAIL midreset_repress edge=%0d got press=%b release=%b exp press=%b release=000",
                         e, key_press, key_release, (e == 6) ? 3'b100 : 3'b000);
            end
            tests_run++;
            if (key_level !== ((e >= 6) ? 3'b100 : 3'b000)) begin
                tests_failed++;
                $display("FAIL midreset_level edge=%0d got=%b exp=%b", e, key_level, (e >= 6) ? 3'b100 : 3'b000);
            end
        end
        tests_run++;
        if (keys_export !== 3'b011) begin
            tests_failed++;
            $display("FAIL midreset_export got=%b exp=%b", keys_export, 3'b011);
        end
    endtask

    initial begin
        reset_reset = 1'b1;
        key_raw     = 3'b111;
        #1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
